// File: rtl/riscv_pkg.sv
// Shared types and constants for the integer pipeline: EX control word,
// ALU operation codes and the register-file hit test used by forwarding.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SLL = 3'b001,
        ALU_SRL = 3'b010,
        ALU_SRA = 3'b011,
        ALU_SUB = 3'b100,
        ALU_AND = 3'b101,
        ALU_OR  = 3'b110,
        ALU_XOR = 3'b111
    } alu_op_e;

    typedef struct packed {
        alu_op_e aluctrl;
        logic    alusrc;
        logic    branch;
        logic    memread;
        logic    memwrite;
        logic    regwrite;
    } ex_ctrl_t;

    // x0 is hardwired to zero, so a write to it must never satisfy a reader.
    function automatic logic rf_hit(
        input logic              we,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] rs
    );
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand bypass selector: the youngest in-flight producer (MEM) wins
// over WB, which wins over the value latched from the register file.
module fwd_mux #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = riscv_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] rs_i,
    input  logic [XLEN-1:0]   reg_data_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_regwrite_i,
    input  logic [XLEN-1:0]   mem_result_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_regwrite_i,
    input  logic [XLEN-1:0]   wb_result_i,
    output logic [XLEN-1:0]   operand_o
);
    import riscv_pkg::*;

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = rf_hit(mem_regwrite_i, mem_rd_i, rs_i);
    assign wb_hit  = rf_hit(wb_regwrite_i, wb_rd_i, rs_i);

    always_comb begin
        operand_o = reg_data_i;
        if (mem_hit) begin
            operand_o = mem_result_i;
        end else if (wb_hit) begin
            operand_o = wb_result_i;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection;
// feeds ALUop1/ALUop2/ALUctrl and the store-data path of the EX stage.
module ex_operand_stage #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = riscv_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [7:0]        id_ctrl,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic              hold,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [XLEN-1:0]   mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic [XLEN-1:0]   wb_result,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [7:0]        ex_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ALUop1,
    output logic [XLEN-1:0]   ALUop2,
    output logic [2:0]        ALUctrl,
    output logic [XLEN-1:0]   ex_store_data
);
    import riscv_pkg::*;

    logic              valid_q, valid_d;
    ex_ctrl_t          ctrl_q,  ctrl_d;
    logic [REG_AW-1:0] rs1_q,   rs1_d;
    logic [REG_AW-1:0] rs2_q,   rs2_d;
    logic [REG_AW-1:0] rd_q,    rd_d;
    logic [XLEN-1:0]   a_q,     a_d;
    logic [XLEN-1:0]   b_q,     b_d;
    logic [XLEN-1:0]   imm_q,   imm_d;

    logic [XLEN-1:0]   id_a_wt;
    logic [XLEN-1:0]   id_b_wt;
    logic [XLEN-1:0]   a_fwd;
    logic [XLEN-1:0]   b_fwd;
    logic              rs_uses_load;

    // The register file is written at the end of WB, so its read port still
    // holds the stale value in the same cycle; take the WB result instead.
    assign id_a_wt = rf_hit(wb_regwrite, wb_rd, id_rs1) ? wb_result : id_rs1_data;
    assign id_b_wt = rf_hit(wb_regwrite, wb_rd, id_rs2) ? wb_result : id_rs2_data;

    assign rs_uses_load = (id_rs1 == rd_q) || (id_rs2 == rd_q);
    assign stall_id = valid_q && ctrl_q.memread && (rd_q != '0) && id_valid
                      && rs_uses_load && !flush;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        a_d     = a_q;
        b_d     = b_q;
        imm_d   = imm_q;
        if (hold) begin
            valid_d = valid_q;
        end else if (flush || stall_id) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            a_d     = '0;
            b_d     = '0;
            imm_d   = '0;
        end else begin
            valid_d = id_valid;
            ctrl_d  = id_valid ? ex_ctrl_t'(id_ctrl) : '0;
            rs1_d   = id_rs1;
            rs2_d   = id_rs2;
            rd_d    = id_rd;
            a_d     = id_a_wt;
            b_d     = id_b_wt;
            imm_d   = id_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_i           (rs1_q),
        .reg_data_i     (a_q),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .mem_result_i   (mem_result),
        .wb_rd_i        (wb_rd),
        .wb_regwrite_i  (wb_regwrite),
        .wb_result_i    (wb_result),
        .operand_o      (a_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_i           (rs2_q),
        .reg_data_i     (b_q),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .mem_result_i   (mem_result),
        .wb_rd_i        (wb_rd),
        .wb_regwrite_i  (wb_regwrite),
        .wb_result_i    (wb_result),
        .operand_o      (b_fwd)
    );

    assign ex_valid      = valid_q;
    assign ex_ctrl       = ctrl_q;
    assign ex_rd         = rd_q;
    assign ALUctrl       = ctrl_q.aluctrl;
    assign ALUop1        = a_fwd;
    assign ALUop2        = ctrl_q.alusrc ? imm_q : b_fwd;
    assign ex_store_data = b_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: reset sequences, a directed vector table and
// a randomized run against a behavioural model of the EX slot.
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [7:0]  id_ctrl;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        hold, flush;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_result;
    logic        stall_id, ex_valid;
    logic [7:0]  ex_ctrl;
    logic [4:0]  ex_rd;
    logic [31:0] ALUop1, ALUop2, ex_store_data;
    logic [2:0]  ALUctrl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .hold(hold), .flush(flush),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
        .stall_id(stall_id), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUctrl(ALUctrl),
        .ex_store_data(ex_store_data)
    );

    typedef struct {
        logic        valid;
        logic [7:0]  ctrl;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        hold, flush;
        logic [4:0]  mrd;
        logic        mwe;
        logic [31:0] mres;
        logic [4:0]  wrd;
        logic        wwe;
        logic [31:0] wres;
        logic        e_stall, e_valid;
        logic [7:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic [31:0] e_op1, e_op2, e_sd;
    } vec_t;

    function automatic vec_t mk(int valid, int ctrl, int rs1, int rs2, int rd,
                                int d1, int d2, int imm, int hld, int fl,
                                int mrd, int mwe, int mres, int wrd, int wwe, int wres,
                                int es, int ev, int ec, int erd, int eo1, int eo2, int esd);
        vec_t v;
        v.valid = 1'(valid); v.ctrl = 8'(ctrl);
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.d1 = 32'(d1); v.d2 = 32'(d2); v.imm = 32'(imm);
        v.hold = 1'(hld); v.flush = 1'(fl);
        v.mrd = 5'(mrd); v.mwe = 1'(mwe); v.mres = 32'(mres);
        v.wrd = 5'(wrd); v.wwe = 1'(wwe); v.wres = 32'(wres);
        v.e_stall = 1'(es); v.e_valid = 1'(ev); v.e_ctrl = 8'(ec); v.e_rd = 5'(erd);
        v.e_op1 = 32'(eo1); v.e_op2 = 32'(eo2); v.e_sd = 32'(esd);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        id_valid = v.valid; id_ctrl = v.ctrl;
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        id_rs1_data = v.d1; id_rs2_data = v.d2; id_imm = v.imm;
        hold = v.hold; flush = v.flush;
        mem_rd = v.mrd; mem_regwrite = v.mwe; mem_result = v.mres;
        wb_rd = v.wrd; wb_regwrite = v.wwe; wb_result = v.wres;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic es, input logic ev,
                             input logic [7:0] ec, input logic [4:0] erd,
                             input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] sd);
        chk({tag, " stall_id"}, 32'(stall_id), 32'(es));
        chk({tag, " ex_valid"}, 32'(ex_valid), 32'(ev));
        chk({tag, " ex_ctrl"}, 32'(ex_ctrl), 32'(ec));
        chk({tag, " ex_rd"}, 32'(ex_rd), 32'(erd));
        chk({tag, " ALUctrl"}, 32'(ALUctrl), 32'(ec[7:5]));
        chk({tag, " ALUop1"}, ALUop1, o1);
        chk({tag, " ALUop2"}, ALUop2, o2);
        chk({tag, " ex_store_data"}, ex_store_data, sd);
    endtask

    // Behavioural model of the EX slot.
    logic        m_valid;
    logic [7:0]  m_ctrl;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_a, m_b, m_imm;

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] latched);
        if (rs == 0) return latched;
        if (mem_regwrite && mem_rd == rs) return mem_result;
        if (wb_regwrite && wb_rd == rs) return wb_result;
        return latched;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] rs, input logic [31:0] rf_data);
        if (rs != 0 && wb_regwrite && wb_rd == rs) return wb_result;
        return rf_data;
    endfunction

    vec_t tbl[23];
    vec_t idle;

    initial begin
        logic        e_stall;
        logic [31:0] e_b;
        idle = mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0);

        //              v ctrl   rs1 rs2 rd d1      d2      imm h f  mrd mwe mres    wrd wwe wres     es ev ectrl erd op1     op2     sd
        tbl[0]  = mk(1,'h11, 1,0,4, 5,9,7,                0,0, 0,0,0,       0,0,0,        0,0,0,    0,0,0,0);
        tbl[1]  = mk(1,'h01, 3,2,6, 'h111,'h222,0,        0,0, 0,0,0,       0,0,0,        0,1,'h11, 4,5,7,9);
        tbl[2]  = mk(0,0,    0,0,0, 0,0,0,                1,0, 3,1,'h10,    3,1,'h20,     0,1,'h01, 6,'h10,'h222,'h222);
        tbl[3]  = mk(0,0,    0,0,0, 0,0,0,                1,0, 3,0,'h10,    3,1,'h20,     0,1,'h01, 6,'h20,'h222,'h222);
        tbl[4]  = mk(1,'h01, 0,0,7, 'h55,'h66,0,          0,0, 2,1,'h33,    2,1,'h44,     0,1,'h01, 6,'h111,'h33,'h33);
        tbl[5]  = mk(0,0,    0,0,0, 0,0,0,                0,0, 0,1,'hDEAD,  0,1,'hBEEF,   0,1,'h01, 7,'h55,'h66,'h66);
        tbl[6]  = mk(1,'h01, 1,2,8, 1,0,0,                0,0, 0,0,0,       2,1,'hAB,     0,0,0,    0,0,0,0);
        tbl[7]  = mk(0,0,    0,0,0, 0,0,0,                0,0, 0,0,0,       0,0,0,        0,1,'h01, 8,1,'hAB,'hAB);
        tbl[8]  = mk(1,'h15, 1,0,5, 'h100,0,4,            0,0, 0,0,0,       0,0,0,        0,0,0,    0,0,0,0);
        tbl[9]  = mk(1,'h01, 5,1,6, 0,7,0,                0,0, 0,0,0,       0,0,0,        1,1,'h15, 5,'h100,4,0);
        tbl[10] = mk(1,'h01, 5,1,6, 0,7,0,                0,0, 5,1,'h99,    0,0,0,        0,0,0,    0,0,0,0);
        tbl[11] = mk(0,0,    0,0,0, 0,0,0,                0,0, 0,0,0,       5,1,'h99,     0,1,'h01, 6,'h99,7,7);
        tbl[12] = mk(1,'h15, 0,0,5, 0,0,8,                0,0, 0,0,0,       0,0,0,        0,0,0,    0,0,0,0);
        tbl[13] = mk(1,'h01, 5,1,6, 0,7,0,                0,1, 0,0,0,       0,0,0,        0,1,'h15, 5,0,8,0);
        tbl[14] = mk(0,0,    0,0,0, 0,0,0,                0,0, 0,0,0,       0,0,0,        0,0,0,    0,0,0,0);
        tbl[15] = mk(1,'h21, 1,2,9, 3,4,0,                0,0, 0,0,0,       0,0,0,        0,0,0,    0,0,0,0);
        tbl[16] = mk(0,0,    0,0,0, 0,0,0,                1,1, 0,0,0,       0,0,0,        0,1,'h21, 9,3,4,4);
        tbl[17] = mk(0,0,    0,0,0, 0,0,0,                0,0, 0,0,0,       0,0,0,        0,1,'h21, 9,3,4,4);
        tbl[18] = mk(0,0,    0,0,0, 0,0,0,                0,0, 0,0,0,       0,0,0,        0,0,0,    0,0,0,0);
        tbl[19] = mk(1,'h15, 1,0,5, 0,0,0,                0,0, 0,0,0,       0,0,0,        0,0,0,    0,0,0,0);
        tbl[20] = mk(1,'h01, 1,5,6, 0,0,0,                1,0, 0,0,0,       0,0,0,        1,1,'h15, 5,0,0,0);
        tbl[21] = mk(1,'h01, 1,5,6, 0,0,0,                0,0, 0,0,0,       0,0,0,        1,1,'h15, 5,0,0,0);
        tbl[22] = mk(1,'h01, 1,5,6, 0,0,0,                0,0, 0,0,0,       0,0,0,        0,0,0,    0,0,0,0);

        // Reset held while decode presents a live instruction.
        apply(idle);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        apply(mk(1,'h11, 1,0,4, 5,9,7, 0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        @(posedge clk);
        #3;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("release", 0, 1, 'h11, 4, 5, 7, 9);
        apply(idle);
        @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i]);
            #3;
            check_all($sformatf("vec%0d", i), tbl[i].e_stall, tbl[i].e_valid, tbl[i].e_ctrl,
                      tbl[i].e_rd, tbl[i].e_op1, tbl[i].e_op2, tbl[i].e_sd);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between clock edges discards the instruction.
        apply(mk(1,'h11, 1,0,4, 5,9,7, 0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0,0));
        @(posedge clk);
        #1;
        apply(idle);
        #1 rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        m_valid = 0; m_ctrl = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_a = 0; m_b = 0; m_imm = 0;
        for (int c = 0; c < 400; c++) begin
            id_valid = 1'($urandom_range(0, 3) != 0);
            id_ctrl = 8'($urandom);
            id_rs1 = 5'($urandom_range(0, 7));
            id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7));
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            hold = 1'($urandom_range(0, 9) == 0);
            flush = 1'($urandom_range(0, 9) == 0);
            mem_rd = 5'($urandom_range(0, 7)); mem_regwrite = 1'($urandom);
            mem_result = $urandom;
            wb_rd = 5'($urandom_range(0, 7)); wb_regwrite = 1'($urandom);
            wb_result = $urandom;
            #3;
            e_stall = m_valid && m_ctrl[2] && m_rd != 0 && id_valid
                      && (id_rs1 == m_rd || id_rs2 == m_rd) && !flush;
            e_b = ref_fwd(m_rs2, m_b);
            check_all($sformatf("rnd%0d", c), e_stall, m_valid, m_ctrl, m_rd,
                      ref_fwd(m_rs1, m_a), m_ctrl[4] ? m_imm : e_b, e_b);
            @(posedge clk);
            if (hold) begin
                // slot keeps its contents
            end else if (flush || e_stall) begin
                m_valid = 0; m_ctrl = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
                m_a = 0; m_b = 0; m_imm = 0;
            end else begin
                m_valid = id_valid;
                m_ctrl = id_valid ? id_ctrl : 8'h00;
                m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
                m_a = ref_read(id_rs1, id_rs1_data);
                m_b = ref_read(id_rs2, id_rs2_data);
                m_imm = id_imm;
            end
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
